// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - ALU op-select codes, flag bit positions and shared helpers
package alu_share_arbiter_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_LESS = 1;
    localparam int FLAG_GE   = 2;

    // Index width for an n-entry vector; never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester, ALU and response bundle for the shared-ALU arbiter
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4,
    parameter int ID_W    = 3
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [32*NUM_REQ-1:0]    req_op_a;
    logic [32*NUM_REQ-1:0]    req_op_b;
    logic [4*NUM_REQ-1:0]     req_alu_sel;
    logic [TAG_W*NUM_REQ-1:0] req_tag;

    logic [31:0]              alu_op_a;
    logic [31:0]              alu_op_b;
    logic [3:0]               alu_sel;
    logic [31:0]              alu_result;
    logic                     alu_zero;
    logic                     alu_less;
    logic                     alu_ge;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [31:0]              rsp_data;
    logic [2:0]               rsp_flags;
    logic [ID_W-1:0]          rsp_id;
    logic [TAG_W-1:0]         rsp_tag;

    // Environment side: requesters, the ALU itself and the response consumer.
    modport master (
        output req_valid, req_op_a, req_op_b, req_alu_sel, req_tag,
        output alu_result, alu_zero, alu_less, alu_ge, rsp_ready,
        input  req_ready, alu_op_a, alu_op_b, alu_sel,
        input  rsp_valid, rsp_data, rsp_flags, rsp_id, rsp_tag
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_op_a, req_op_b, req_alu_sel, req_tag,
        input  alu_result, alu_zero, alu_less, alu_ge, rsp_ready,
        output req_ready, alu_op_a, alu_op_b, alu_sel,
        output rsp_valid, rsp_data, rsp_flags, rsp_id, rsp_tag
    );
endinterface

// File: rtl/alu_share_arbiter_rr_pick.sv
// rtl/alu_share_arbiter_rr_pick.sv - combinational round-robin pick starting after ptr
module rr_priority_pick
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    int cand;

    // Scan ptr+1, ptr+2, ... with wrap; the first asserted request wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!grant_any && req[cand]) begin
                grant_any   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin share of one ALU with a one-deep response register; ALU_ARB_STATS_EN adds counters
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4,
    parameter int ID_W    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    alu_share_arbiter_if.slave      bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [16*NUM_REQ-1:0]   stat_grant_cnt,
    output logic [15:0]             stat_stall_cnt
`endif
);

    localparam int IDX_W = idx_width(NUM_REQ);

    logic               rsp_valid;
    logic [31:0]        rsp_data;
    logic [2:0]         rsp_flags;
    logic [ID_W-1:0]    rsp_id;
    logic [TAG_W-1:0]   rsp_tag;
    logic [IDX_W-1:0]   ptr;

    logic               can_issue;
    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               fire;
    logic [TAG_W-1:0]   sel_tag;

    // A draining response frees the register in the same cycle.
    assign can_issue = !rsp_valid || bus.rsp_ready;
    assign pick_req  = can_issue ? bus.req_valid : '0;

    rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req       (pick_req),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (fire)
    );

    assign bus.req_ready = grant;

    // Winner's payload to the ALU; idle drives ADD 0+0 to keep the datapath quiet.
    always_comb begin
        bus.alu_op_a = '0;
        bus.alu_op_b = '0;
        bus.alu_sel  = ALU_ADD;
        sel_tag      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                bus.alu_op_a = bus.req_op_a[32*i +: 32];
                bus.alu_op_b = bus.req_op_b[32*i +: 32];
                bus.alu_sel  = bus.req_alu_sel[4*i +: 4];
                sel_tag      = bus.req_tag[TAG_W*i +: TAG_W];
            end
        end
    end

    // Response register: load on accept, clear on drain, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_id    <= '0;
            rsp_tag   <= '0;
            ptr       <= IDX_W'(NUM_REQ - 1);
        end else if (fire) begin
            rsp_valid            <= 1'b1;
            rsp_data             <= bus.alu_result;
            rsp_flags[FLAG_GE]   <= bus.alu_ge;
            rsp_flags[FLAG_LESS] <= bus.alu_less;
            rsp_flags[FLAG_ZERO] <= bus.alu_zero;
            rsp_id               <= ID_W'(grant_idx);
            rsp_tag              <= sel_tag;
            ptr                  <= grant_idx;
        end else if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data;
    assign bus.rsp_flags = rsp_flags;
    assign bus.rsp_id    = rsp_id;
    assign bus.rsp_tag   = rsp_tag;

`ifdef ALU_ARB_STATS_EN
    // Saturating per-requester grant counts and a count of cycles with demand but no grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grant_cnt <= '0;
            stat_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && stat_grant_cnt[16*i +: 16] != 16'hFFFF)
                    stat_grant_cnt[16*i +: 16] <= stat_grant_cnt[16*i +: 16] + 16'd1;
            end
            if (|bus.req_valid && !fire && stat_stall_cnt != 16'hFFFF)
                stat_stall_cnt <= stat_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int TAG_W   = 4;
    localparam int ID_W    = 3;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic done;

    alu_share_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .ID_W(ID_W)) bus ();

`ifdef ALU_ARB_STATS_EN
    logic [16*NUM_REQ-1:0] stat_grant_cnt;
    logic [15:0]           stat_stall_cnt;
`endif

    alu_share_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .ID_W(ID_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_grant_cnt (stat_grant_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference integer ALU hanging off the shared operand bus.
    always_comb begin
        case (bus.alu_sel)
            ALU_ADD:  bus.alu_result = bus.alu_op_a + bus.alu_op_b;
            ALU_SUB:  bus.alu_result = bus.alu_op_a - bus.alu_op_b;
            ALU_AND:  bus.alu_result = bus.alu_op_a & bus.alu_op_b;
            ALU_OR:   bus.alu_result = bus.alu_op_a | bus.alu_op_b;
            ALU_XOR:  bus.alu_result = bus.alu_op_a ^ bus.alu_op_b;
            ALU_SLL:  bus.alu_result = bus.alu_op_a << bus.alu_op_b[4:0];
            ALU_SRL:  bus.alu_result = bus.alu_op_a >> bus.alu_op_b[4:0];
            ALU_SRA:  bus.alu_result = $signed(bus.alu_op_a) >>> bus.alu_op_b[4:0];
            ALU_SLT:  bus.alu_result = {31'd0, $signed(bus.alu_op_a) < $signed(bus.alu_op_b)};
            ALU_SLTU: bus.alu_result = {31'd0, bus.alu_op_a < bus.alu_op_b};
            default:  bus.alu_result = 32'd0;
        endcase
        bus.alu_zero = (bus.alu_op_a == bus.alu_op_b);
        bus.alu_less = ($signed(bus.alu_op_a) < $signed(bus.alu_op_b));
        bus.alu_ge   = ($signed(bus.alu_op_a) >= $signed(bus.alu_op_b));
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] sel, input logic [TAG_W-1:0] tag);
        bus.req_op_a[32*i +: 32]       = a;
        bus.req_op_b[32*i +: 32]       = b;
        bus.req_alu_sel[4*i +: 4]      = sel;
        bus.req_tag[TAG_W*i +: TAG_W]  = tag;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [ID_W-1:0]  exp_id [4];

    initial begin
        done = 1'b0;
        #100000;
        if (!done) begin
            n_fail++;
            $error("FAIL timeout: directed sequence did not complete");
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.req_valid   = '0;
        bus.req_op_a    = '0;
        bus.req_op_b    = '0;
        bus.req_alu_sel = '0;
        bus.req_tag     = '0;
        bus.rsp_ready   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_valid", bus.rsp_valid, 1'b0);
        check("rst_data",  bus.rsp_data,  32'd0);
        check("rst_flags", bus.rsp_flags, 3'b000);
        check("rst_id",    bus.rsp_id,    3'd0);
        check("rst_tag",   bus.rsp_tag,   4'h0);

        // Single SUB from req0: 5-3
        set_req(0, 32'd5, 32'd3, ALU_SUB, 4'hA);
        bus.req_valid = 2'b01;
        bus.rsp_ready = 1'b1;
        #1;
        check("sub_ready", bus.req_ready, 2'b01);
        check("sub_alu_a", bus.alu_op_a,  32'd5);
        tick();
        bus.req_valid = 2'b00;
        check("sub_valid", bus.rsp_valid, 1'b1);
        check("sub_data",  bus.rsp_data,  32'd2);
        check("sub_flags", bus.rsp_flags, 3'b100);
        check("sub_id",    bus.rsp_id,    3'd0);
        check("sub_tag",   bus.rsp_tag,   4'hA);
        #1;
        check("idle_ready", bus.req_ready, 2'b00);
        check("idle_alu_a", bus.alu_op_a,  32'd0);
        check("idle_sel",   bus.alu_sel,   4'b0000);
        tick();
        check("drain_valid", bus.rsp_valid, 1'b0);

        // Both requesters continuously valid; ptr=0 so req1 goes first
        set_req(0, 32'd10, 32'd1, ALU_ADD, 4'h1);
        set_req(1, 32'd20, 32'd2, ALU_SUB, 4'h2);
        bus.req_valid = 2'b11;
        exp_id[0] = 3'd1; exp_id[1] = 3'd0; exp_id[2] = 3'd1; exp_id[3] = 3'd0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_ready", bus.req_ready, (exp_id[k] == 3'd1) ? 2'b10 : 2'b01);
            tick();
            check("rr_valid", bus.rsp_valid, 1'b1);
            check("rr_id",    bus.rsp_id,    exp_id[k]);
            check("rr_data",  bus.rsp_data,  (exp_id[k] == 3'd1) ? 32'd18 : 32'd11);
            check("rr_tag",   bus.rsp_tag,   (exp_id[k] == 3'd1) ? 4'h2 : 4'h1);
        end

        // Backpressure: response held for 3 cycles
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_ready", bus.req_ready, 2'b00);
            tick();
            check("stall_valid", bus.rsp_valid, 1'b1);
            check("stall_id",    bus.rsp_id,    3'd0);
            check("stall_data",  bus.rsp_data,  32'd11);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("unstall_ready", bus.req_ready, 2'b10);
        tick();
        check("unstall_id",   bus.rsp_id,   3'd1);
        check("unstall_data", bus.rsp_data, 32'd18);

        // Signed vs unsigned compare from req1: -1 vs 1
        bus.req_valid = 2'b10;
        set_req(1, 32'hFFFF_FFFF, 32'd1, ALU_SLT, 4'h5);
        #1;
        check("slt_ready", bus.req_ready, 2'b10);
        tick();
        check("slt_data",  bus.rsp_data,  32'd1);
        check("slt_flags", bus.rsp_flags, 3'b010);
        check("slt_id",    bus.rsp_id,    3'd1);
        set_req(1, 32'hFFFF_FFFF, 32'd1, ALU_SLTU, 4'h6);
        tick();
        check("sltu_data",  bus.rsp_data,  32'd0);
        check("sltu_flags", bus.rsp_flags, 3'b010);
        check("sltu_tag",   bus.rsp_tag,   4'h6);

        // Illegal select: result 0, flags still captured
        bus.req_valid = 2'b01;
        set_req(0, 32'd7, 32'd7, 4'hF, 4'h9);
        tick();
        check("ill_data",  bus.rsp_data,  32'd0);
        check("ill_flags", bus.rsp_flags, 3'b101);
        check("ill_id",    bus.rsp_id,    3'd0);

        // Reset right after a grant drops the response and restores ptr
        bus.req_valid = 2'b11;
        tick();
        check("pre_rst_id", bus.rsp_id, 3'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", bus.rsp_valid, 1'b0);
        check("mid_rst_data",  bus.rsp_data,  32'd0);
        check("mid_rst_id",    bus.rsp_id,    3'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", bus.req_ready, 2'b01);
        tick();
        check("post_rst_id",   bus.rsp_id,   3'd0);
        check("post_rst_data", bus.rsp_data, 32'd0);

`ifdef ALU_ARB_STATS_EN
        // 10 grants to req0, then 4 stalled cycles
        bus.req_valid = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_valid = 2'b01;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        bus.req_valid = 2'b00;
        check("stat_grant0", stat_grant_cnt[15:0],  16'd10);
        check("stat_grant1", stat_grant_cnt[31:16], 16'd0);
        check("stat_stall",  stat_stall_cnt,        16'd4);
`endif

        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
